// File: rtl/red_pitaya_dac_pkg.sv
// Shared definitions for the DAC output-conditioning stage.
// The state encoding is also decoded by the register-map readback.
package red_pitaya_dac_pkg;

   typedef enum logic [1:0] {
      OFF       = 2'd0,
      RAMP_UP   = 2'd1,
      TRACK     = 2'd2,
      RAMP_DOWN = 2'd3
   } slew_state_t;

endpackage

// File: rtl/red_pitaya_dac_slew_if.sv
// Sample/control bundle between an ASG channel and its slew-limiting output stage.
interface red_pitaya_dac_slew_if #(
   parameter int DW = 14
);
   logic signed [DW-1:0] dat_i;
   logic                 en_i;
   logic        [DW-1:0] set_step_i;
   logic                 set_lim_i;
   logic signed [DW-1:0] dac_o;
   logic                 busy_o;
   logic                 lim_o;
   logic          [1:0]  state_o;

   modport master (
      output dat_i, en_i, set_step_i, set_lim_i,
      input  dac_o, busy_o, lim_o, state_o
   );

   modport slave (
      input  dat_i, en_i, set_step_i, set_lim_i,
      output dac_o, busy_o, lim_o, state_o
   );
endinterface

// File: rtl/red_pitaya_slew_step.sv
// One slew-limited move from cur toward tgt; step==0 means an unlimited jump.
module red_pitaya_slew_step #(
   parameter int DW = 14
) (
   input  logic signed [DW-1:0] cur,
   input  logic signed [DW-1:0] tgt,
   input  logic        [DW-1:0] step,
   output logic signed [DW-1:0] next,
   output logic                 catch
);
   logic signed [DW:0] diff;
   logic        [DW:0] mag;
   logic        [DW:0] moved;

   always_comb begin
      // One extra bit keeps a full rail-to-rail difference representable.
      diff  = {tgt[DW-1], tgt} - {cur[DW-1], cur};
      mag   = diff[DW] ? $unsigned(-diff) : $unsigned(diff);
      catch = (step == '0) || (mag <= {1'b0, step});
      moved = diff[DW] ? ({cur[DW-1], cur} - {1'b0, step})
                       : ({cur[DW-1], cur} + {1'b0, step});
      next  = catch ? tgt : $signed(moved[DW-1:0]);
   end
endmodule

// File: rtl/red_pitaya_dac_slew.sv
// Per-channel DAC output conditioner: slew-rate limit plus soft ramp on enable/disable.
module red_pitaya_dac_slew
   import red_pitaya_dac_pkg::*;
#(
   parameter int DW = 14
) (
   input  logic                 dac_clk_i,
   input  logic                 dac_rst_i,
   red_pitaya_dac_slew_if.slave bus
);
   slew_state_t          state, state_nxt;
   logic signed [DW-1:0] dac, dac_nxt;
   logic                 lim, lim_nxt;
   logic signed [DW-1:0] tgt, step_next;
   logic                 step_catch;

   assign tgt = (state == RAMP_DOWN) ? '0 : bus.dat_i;

   red_pitaya_slew_step #(.DW(DW)) u_step (
      .cur   (dac),
      .tgt   (tgt),
      .step  (bus.set_step_i),
      .next  (step_next),
      .catch (step_catch)
   );

   always_comb begin
      state_nxt = state;
      dac_nxt   = dac;
      lim_nxt   = lim;
      // An enable change wins over catch and freezes the output for that edge.
      unique case (state)
         OFF: begin
            dac_nxt = '0;
            lim_nxt = 1'b0;
            if (bus.en_i) state_nxt = RAMP_UP;
         end
         RAMP_UP: begin
            if (!bus.en_i) begin
               state_nxt = RAMP_DOWN;
            end else begin
               dac_nxt = step_next;
               lim_nxt = !step_catch;
               if (step_catch) state_nxt = TRACK;
            end
         end
         TRACK: begin
            if (!bus.en_i) begin
               state_nxt = RAMP_DOWN;
            end else if (bus.set_lim_i) begin
               dac_nxt = step_next;
               lim_nxt = !step_catch;
            end else begin
               dac_nxt = bus.dat_i;
               lim_nxt = 1'b0;
            end
         end
         RAMP_DOWN: begin
            if (bus.en_i) begin
               state_nxt = RAMP_UP;
            end else begin
               dac_nxt = step_next;
               lim_nxt = !step_catch;
               if (step_catch) state_nxt = OFF;
            end
         end
         default: state_nxt = OFF;
      endcase
   end

   always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
      if (dac_rst_i) begin
         state <= OFF;
         dac   <= '0;
         lim   <= 1'b0;
      end else begin
         state <= state_nxt;
         dac   <= dac_nxt;
         lim   <= lim_nxt;
      end
   end

   assign bus.dac_o   = dac;
   assign bus.lim_o   = lim;
   assign bus.busy_o  = (state == RAMP_UP) || (state == RAMP_DOWN);
   assign bus.state_o = state;
endmodule

// File: tb/tb_red_pitaya_dac_slew.sv
// Self-checking bench for red_pitaya_dac_slew against an integer reference model.
module tb_red_pitaya_dac_slew;
   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   red_pitaya_dac_slew_if #(.DW(14)) bus ();

   red_pitaya_dac_slew #(.DW(14)) dut (
      .dac_clk_i (clk),
      .dac_rst_i (rst),
      .bus       (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: 0=OFF 1=RAMP_UP 2=TRACK 3=RAMP_DOWN
   int m_state;
   int m_dac;
   bit m_lim;

   function automatic void model_reset();
      m_state = 0;
      m_dac   = 0;
      m_lim   = 1'b0;
   endfunction

   function automatic void model_step();
      int tgt, d, ad, st, nv;
      bit c;
      st  = int'(bus.set_step_i);
      tgt = (m_state == 3) ? 0 : int'($signed(bus.dat_i));
      d   = tgt - m_dac;
      ad  = (d < 0) ? -d : d;
      c   = (st == 0) || (ad <= st);
      nv  = c ? tgt : ((d > 0) ? m_dac + st : m_dac - st);
      case (m_state)
         0: begin
            m_dac = 0; m_lim = 1'b0;
            if (bus.en_i) m_state = 1;
         end
         1: begin
            if (!bus.en_i) m_state = 3;
            else begin
               m_dac = nv; m_lim = !c;
               if (c) m_state = 2;
            end
         end
         2: begin
            if (!bus.en_i) m_state = 3;
            else if (bus.set_lim_i) begin
               m_dac = nv; m_lim = !c;
            end else begin
               m_dac = int'($signed(bus.dat_i)); m_lim = 1'b0;
            end
         end
         default: begin
            if (bus.en_i) m_state = 1;
            else begin
               m_dac = nv; m_lim = !c;
               if (c) m_state = 0;
            end
         end
      endcase
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.en_i = 1'b0; bus.dat_i = '0; bus.set_step_i = '0; bus.set_lim_i = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ($signed(bus.dac_o) !== 0) begin n_fail++; $display("FAIL reset_dac: got %0d want 0", $signed(bus.dac_o)); end
      n_checks++;
      if (bus.state_o !== 2'd0 || bus.busy_o !== 1'b0 || bus.lim_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags: state=%0d busy=%0b lim=%0b want 0/0/0", bus.state_o, bus.busy_o, bus.lim_o);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_ramp_up();
      bus.dat_i = 14'sd1000; bus.set_step_i = 14'd100; bus.set_lim_i = 1'b0; bus.en_i = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         int  exp_dac;
         int  exp_st;
         bit  exp_lim;
         tick();
         exp_dac = (k - 1) * 100;
         exp_st  = (k < 11) ? 1 : 2;
         exp_lim = (k >= 2) && (k <= 10);
         n_checks++;
         if ($signed(bus.dac_o) !== exp_dac) begin n_fail++; $display("FAIL ramp_dac[%0d]: got %0d want %0d", k, $signed(bus.dac_o), exp_dac); end
         n_checks++;
         if (int'(bus.state_o) !== exp_st || bus.busy_o !== (k < 11)) begin
            n_fail++; $display("FAIL ramp_state[%0d]: state=%0d busy=%0b want %0d/%0b", k, bus.state_o, bus.busy_o, exp_st, k < 11);
         end
         n_checks++;
         if (bus.lim_o !== exp_lim) begin n_fail++; $display("FAIL ramp_lim[%0d]: got %0b want %0b", k, bus.lim_o, exp_lim); end
      end
   endtask

   task automatic test_passthru();
      int seq [2] = '{-8192, 8191};
      foreach (seq[i]) begin
         bus.dat_i = 14'(seq[i]);
         tick();
         n_checks++;
         if ($signed(bus.dac_o) !== seq[i] || bus.lim_o !== 1'b0 || bus.state_o !== 2'd2) begin
            n_fail++; $display("FAIL passthru[%0d]: dac=%0d lim=%0b state=%0d want %0d/0/2", i, $signed(bus.dac_o), bus.lim_o, bus.state_o, seq[i]);
         end
      end
   endtask

   task automatic test_rail_to_rail();
      int prev = 8191;
      bus.set_lim_i = 1'b1; bus.set_step_i = 14'd1; bus.dat_i = -14'sd8192;
      for (int i = 1; i <= 16383; i++) begin
         tick();
         n_checks++;
         if ($signed(bus.dac_o) !== prev - 1) begin n_fail++; $display("FAIL rail_step[%0d]: got %0d want %0d", i, $signed(bus.dac_o), prev - 1); end
         prev = prev - 1;
      end
      n_checks++;
      if ($signed(bus.dac_o) !== -8192 || bus.state_o !== 2'd2 || bus.lim_o !== 1'b0) begin
         n_fail++; $display("FAIL rail_end: dac=%0d state=%0d lim=%0b want -8192/2/0", $signed(bus.dac_o), bus.state_o, bus.lim_o);
      end
   endtask

   task automatic test_ramp_abort();
      int exp_dac [6] = '{300, 200, 100, 0, 100, 200};
      int exp_st  [6] = '{3, 3, 3, 0, 1, 1};
      bus.en_i = 1'b0; bus.set_step_i = '0;
      tick(); tick();
      bus.set_lim_i = 1'b0; bus.set_step_i = 14'd100; bus.dat_i = 14'sd1000; bus.en_i = 1'b1;
      repeat (4) tick();
      n_checks++;
      if ($signed(bus.dac_o) !== 300 || bus.state_o !== 2'd1) begin
         n_fail++; $display("FAIL abort_pre: dac=%0d state=%0d want 300/1", $signed(bus.dac_o), bus.state_o);
      end
      bus.en_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if ($signed(bus.dac_o) !== exp_dac[i] || int'(bus.state_o) !== exp_st[i]) begin
            n_fail++; $display("FAIL abort_down[%0d]: dac=%0d state=%0d want %0d/%0d", i, $signed(bus.dac_o), bus.state_o, exp_dac[i], exp_st[i]);
         end
      end
      bus.en_i = 1'b1;
      repeat (3) tick();
      bus.en_i = 1'b0;
      tick(); tick();
      n_checks++;
      if ($signed(bus.dac_o) !== 100 || bus.state_o !== 2'd3) begin
         n_fail++; $display("FAIL resume_pre: dac=%0d state=%0d want 100/3", $signed(bus.dac_o), bus.state_o);
      end
      bus.en_i = 1'b1;
      for (int i = 4; i < 6; i++) begin
         tick();
         n_checks++;
         if ($signed(bus.dac_o) !== exp_dac[i] || int'(bus.state_o) !== exp_st[i]) begin
            n_fail++; $display("FAIL resume[%0d]: dac=%0d state=%0d want %0d/%0d", i, $signed(bus.dac_o), bus.state_o, exp_dac[i], exp_st[i]);
         end
      end
   endtask

   task automatic test_zero_step();
      int v = int'($urandom_range(1, 8191));
      if ($urandom_range(0, 1) == 1) v = -v;
      bus.set_step_i = '0; bus.en_i = 1'b0;
      tick(); tick();
      bus.dat_i = 14'(v); bus.en_i = 1'b1;
      tick();
      n_checks++;
      if ($signed(bus.dac_o) !== 0 || bus.state_o !== 2'd1) begin n_fail++; $display("FAIL zero_up1: dac=%0d state=%0d want 0/1", $signed(bus.dac_o), bus.state_o); end
      tick();
      n_checks++;
      if ($signed(bus.dac_o) !== v || bus.state_o !== 2'd2 || bus.lim_o !== 1'b0) begin
         n_fail++; $display("FAIL zero_up2: dac=%0d state=%0d lim=%0b want %0d/2/0", $signed(bus.dac_o), bus.state_o, bus.lim_o, v);
      end
      bus.en_i = 1'b0;
      tick();
      n_checks++;
      if ($signed(bus.dac_o) !== v || bus.state_o !== 2'd3 || bus.lim_o !== 1'b0) begin
         n_fail++; $display("FAIL zero_dn1: dac=%0d state=%0d lim=%0b want %0d/3/0", $signed(bus.dac_o), bus.state_o, bus.lim_o, v);
      end
      tick();
      n_checks++;
      if ($signed(bus.dac_o) !== 0 || bus.state_o !== 2'd0 || bus.lim_o !== 1'b0) begin
         n_fail++; $display("FAIL zero_dn2: dac=%0d state=%0d lim=%0b want 0/0/0", $signed(bus.dac_o), bus.state_o, bus.lim_o);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 4)  bus.en_i = ~bus.en_i;
         if ($urandom_range(0, 99) < 25) bus.dat_i = 14'(int'($urandom_range(0, 16383)) - 8192);
         if ($urandom_range(0, 99) < 3) begin
            case ($urandom_range(0, 3))
               0:       bus.set_step_i = '0;
               1:       bus.set_step_i = 14'($urandom_range(1, 16383));
               default: bus.set_step_i = 14'($urandom_range(1, 400));
            endcase
         end
         if ($urandom_range(0, 99) < 2)  bus.set_lim_i = ~bus.set_lim_i;
         tick();
         n_checks++;
         if ($signed(bus.dac_o) !== m_dac || int'(bus.state_o) !== m_state ||
             bus.busy_o !== (m_state == 1 || m_state == 3) || bus.lim_o !== m_lim) begin
            n_fail++;
            $display("FAIL random[%0d]: dac=%0d state=%0d busy=%0b lim=%0b want %0d/%0d/%0b/%0b", i,
                     $signed(bus.dac_o), bus.state_o, bus.busy_o, bus.lim_o,
                     m_dac, m_state, (m_state == 1 || m_state == 3), m_lim);
         end
      end
   endtask

   task automatic test_async_reset();
      bus.en_i = 1'b0; bus.set_step_i = '0;
      repeat (3) tick();
      bus.dat_i = -14'sd1000; bus.set_step_i = 14'd100; bus.set_lim_i = 1'b0; bus.en_i = 1'b1;
      repeat (6) tick();
      n_checks++;
      if ($signed(bus.dac_o) !== -500 || bus.state_o !== 2'd1) begin
         n_fail++; $display("FAIL arst_pre: dac=%0d state=%0d want -500/1", $signed(bus.dac_o), bus.state_o);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ($signed(bus.dac_o) !== 0 || bus.busy_o !== 1'b0 || bus.state_o !== 2'd0 || bus.lim_o !== 1'b0) begin
         n_fail++; $display("FAIL arst_async: dac=%0d busy=%0b state=%0d lim=%0b want 0/0/0/0", $signed(bus.dac_o), bus.busy_o, bus.state_o, bus.lim_o);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.en_i = 1'b0;
      tick();
      n_checks++;
      if ($signed(bus.dac_o) !== 0 || bus.state_o !== 2'd0) begin
         n_fail++; $display("FAIL arst_release: dac=%0d state=%0d want 0/0", $signed(bus.dac_o), bus.state_o);
      end
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_passthru();
      test_rail_to_rail();
      test_ramp_abort();
      test_zero_step();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
